// File: rtl/dds_dac_if.sv
// Serialises each DDS sample pair into two 16-bit DAC frames (channel A, then B)
// and strobes LDAC so both DAC channels update together.
module dds_dac_if #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_0,
  input  logic [7:0] data_pi,
  output logic       sample_ack,
  output logic       busy,
  output logic       overrun,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       dac_ldac_n
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CS_A, SHIFT_A, GAP, CS_B, SHIFT_B, LDAC} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;
  logic [15:0]      frame_a_q;
  logic [15:0]      frame_b_q;
  logic [15:0]      shift_q;
  logic [3:0]       bit_q;
  logic [PH_W-1:0]  ph_q;
  logic [1:0]       ldac_cnt_q;

  // Sample-rate divider runs freely, independent of the transfer state.
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_a_q  <= '0;
      frame_b_q  <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      ph_q       <= '0;
      ldac_cnt_q <= '0;
      sample_ack <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_din    <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      sample_ack <= 1'b0;
      if (tick && state_q != IDLE) overrun <= 1'b1;

      case (state_q)
        IDLE: begin
          if (tick) begin
            frame_a_q  <= {2'b00, 2'b01, data_0, 4'b0000};
            frame_b_q  <= {2'b01, 2'b01, data_pi, 4'b0000};
            sample_ack <= 1'b1;
            busy       <= 1'b1;
            dac_cs_n   <= 1'b0;
            state_q    <= CS_A;
          end
        end

        CS_A, CS_B: begin
          shift_q  <= (state_q == CS_A) ? frame_a_q : frame_b_q;
          dac_din  <= (state_q == CS_A) ? frame_a_q[15] : frame_b_q[15];
          dac_sclk <= 1'b0;
          ph_q     <= '0;
          bit_q    <= '0;
          state_q  <= (state_q == CS_A) ? SHIFT_A : SHIFT_B;
        end

        // dac_sclk doubles as the half-bit phase flag; data only moves when a low phase starts.
        SHIFT_A, SHIFT_B: begin
          if (ph_q == PH_LAST) begin
            ph_q <= '0;
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else if (bit_q == 4'd15) begin
              dac_sclk   <= 1'b0;
              dac_cs_n   <= 1'b1;
              ldac_cnt_q <= '0;
              state_q    <= (state_q == SHIFT_A) ? GAP : LDAC;
            end else begin
              dac_sclk <= 1'b0;
              dac_din  <= shift_q[14];
              shift_q  <= {shift_q[14:0], 1'b0};
              bit_q    <= bit_q + 4'd1;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end

        GAP: begin
          dac_cs_n <= 1'b0;
          state_q  <= CS_B;
        end

        // One cycle of CS-high setup, then LDAC low for two cycles.
        LDAC: begin
          case (ldac_cnt_q)
            2'd0: begin
              dac_ldac_n <= 1'b0;
              ldac_cnt_q <= 2'd1;
            end
            2'd1: begin
              ldac_cnt_q <= 2'd2;
            end
            default: begin
              dac_ldac_n <= 1'b1;
              busy       <= 1'b0;
              dac_din    <= 1'b0;
              ldac_cnt_q <= '0;
              state_q    <= IDLE;
            end
          endcase
        end

        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_dac_if.sv
// Bench for dds_dac_if: default instance decoded against a frame scoreboard,
// plus an overrun-prone instance and a back-to-back (CLK_DIV=1) instance.
module tb_dds_dac_if;
  localparam int CD   = 4;
  localparam int SD   = 512;
  localparam int CD_O = 4;
  localparam int SD_O = 200;
  localparam int CD_F = 1;
  localparam int SD_F = 72;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_0 = 8'd0;
  logic [7:0] data_pi = 8'd0;

  logic ack, busy, ovr, cs_n, sclk, din, ldac_n;
  logic o_ack, o_busy, o_ovr, o_cs_n, o_sclk, o_din, o_ldac_n;
  logic f_ack, f_busy, f_ovr, f_cs_n, f_sclk, f_din, f_ldac_n;

  dds_dac_if #(.CLK_DIV(CD), .SAMPLE_DIV(SD)) u_dut (
    .clk(clk), .rst(rst), .data_0(data_0), .data_pi(data_pi),
    .sample_ack(ack), .busy(busy), .overrun(ovr), .dac_cs_n(cs_n),
    .dac_sclk(sclk), .dac_din(din), .dac_ldac_n(ldac_n)
  );

  dds_dac_if #(.CLK_DIV(CD_O), .SAMPLE_DIV(SD_O)) u_ovr (
    .clk(clk), .rst(rst), .data_0(data_0), .data_pi(data_pi),
    .sample_ack(o_ack), .busy(o_busy), .overrun(o_ovr), .dac_cs_n(o_cs_n),
    .dac_sclk(o_sclk), .dac_din(o_din), .dac_ldac_n(o_ldac_n)
  );

  dds_dac_if #(.CLK_DIV(CD_F), .SAMPLE_DIV(SD_F)) u_fast (
    .clk(clk), .rst(rst), .data_0(data_0), .data_pi(data_pi),
    .sample_ack(f_ack), .busy(f_busy), .overrun(f_ovr), .dac_cs_n(f_cs_n),
    .dac_sclk(f_sclk), .dac_din(f_din), .dac_ldac_n(f_ldac_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // Cycle index since reset release: sample at negedge after k-th posedge sees k.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [15:0] exp_q[$];
  int n_ldac;

  // Main instance monitor: frame decode on rising sclk, timing widths, scoreboard pop.
  initial begin
    logic p_cs, p_sclk, p_ldac, p_busy, p_din, p_ack, hi_din;
    logic [15:0] sh, exp_f;
    int nbits, cs_low, ldac_low, busy_w, last_chg, stab_err, exp_ack;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_cs = 1'b1; p_sclk = 1'b0; p_ldac = 1'b1; p_busy = 1'b0; p_din = 1'b0; p_ack = 1'b0;
        hi_din = 1'b0; sh = '0; nbits = 0; cs_low = 0; ldac_low = 0; busy_w = 0;
        last_chg = 0; stab_err = 0; exp_ack = SD; n_ldac = 0;
      end else begin
        if (ack === 1'b1) begin
          chk("ack_cycle", cyc, exp_ack);
          chk("busy_at_ack", busy, 1'b1);
          exp_ack += SD;
        end
        if (p_ack) chk("ack_width", ack, 1'b0);
        if (din !== p_din) last_chg = cyc;
        if (cs_n === 1'b0) cs_low++;
        if (sclk === 1'b1 && p_sclk === 1'b0) begin
          sh = {sh[14:0], din};
          nbits++;
          if (cyc - last_chg < CD) stab_err++;
          hi_din = din;
        end
        if (sclk === 1'b1 && din !== hi_din) stab_err++;
        if (cs_n === 1'b1 && p_cs === 1'b0) begin
          chk("frame_bits", nbits, 16);
          chk("cs_low_width", cs_low, 1 + 32*CD);
          chk("din_stable", stab_err, 0);
          chk("frame_expected_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            exp_f = exp_q.pop_front();
            chk("frame_data", sh, exp_f);
          end
          nbits = 0; cs_low = 0; stab_err = 0;
        end
        if (ldac_n === 1'b0) begin
          ldac_low++;
          chk("cs_high_in_ldac", cs_n, 1'b1);
        end
        if (ldac_n === 1'b1 && p_ldac === 1'b0) begin
          chk("ldac_width", ldac_low, 2);
          n_ldac++;
          ldac_low = 0;
        end
        if (busy === 1'b1) busy_w++;
        if (busy === 1'b0 && p_busy === 1'b1) begin
          chk("busy_width", busy_w, 64*CD + 6);
          chk("din_idle", din, 1'b0);
          busy_w = 0;
        end
        p_cs = cs_n; p_sclk = sclk; p_ldac = ldac_n; p_busy = busy; p_din = din; p_ack = ack;
      end
    end
  end

  // Overrun instance: busy (262) exceeds the 200-cycle tick period.
  initial begin
    logic p_busy;
    int n_ack;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_busy = 1'b0; n_ack = 0;
      end else begin
        if (o_ack === 1'b1) begin
          n_ack++;
          chk("ovr_ack_not_busy", p_busy, 1'b0);
        end
        if (cyc == 2*SD_O - 1) chk("ovr_before_2nd_tick", o_ovr, 1'b0);
        if (cyc == 2*SD_O) begin
          chk("ovr_after_2nd_tick", o_ovr, 1'b1);
          chk("ovr_ack_count_400", n_ack, 1);
        end
        if (cyc == 5*SD_O + 1) begin
          chk("ovr_sticky", o_ovr, 1'b1);
          chk("ovr_ack_count_1001", n_ack, 3);
        end
        p_busy = o_busy;
      end
    end
  end

  // Back-to-back instance: busy 70, two idle cycles between transfers.
  initial begin
    logic p_busy, gap_ok;
    int bw, gap;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_busy = 1'b0; gap_ok = 1'b0; bw = 0; gap = 0;
      end else begin
        if (f_busy === 1'b1) bw++;
        else gap++;
        if (f_busy === 1'b1 && p_busy === 1'b0) begin
          if (gap_ok) chk("fast_gap", gap, 2);
          chk("fast_ack_with_busy", f_ack, 1'b1);
        end
        if (f_busy === 1'b0 && p_busy === 1'b1) begin
          chk("fast_busy_width", bw, 64*CD_F + 6);
          bw = 0; gap = 1; gap_ok = 1'b1;
        end
        p_busy = f_busy;
      end
    end
  end

  task automatic wait_ack(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < budget);
    chk("ack_wait", ack, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < budget);
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ovr"}, ovr, 1'b0);
    chk({tag, "_cs_n"}, cs_n, 1'b1);
    chk({tag, "_sclk"}, sclk, 1'b0);
    chk({tag, "_din"}, din, 1'b0);
    chk({tag, "_ldac_n"}, ldac_n, 1'b1);
  endtask

  initial begin
    #(20000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    data_0 = 8'd128; data_pi = 8'd128;
    exp_q.push_back(16'h1800); exp_q.push_back(16'h5800);
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_init");
    #2 rst = 1'b0;

    wait_ack(SD + 4);
    data_0 = 8'd219; data_pi = 8'd37;
    exp_q.push_back(16'h1DB0); exp_q.push_back(16'h5250);

    wait_ack(SD + 4);
    data_0 = 8'd255; data_pi = 8'd100;
    exp_q.push_back(16'h1FF0); exp_q.push_back(16'h5640);

    wait_ack(SD + 4);
    repeat (20) @(negedge clk);
    chk("mid_shift_a_busy", busy, 1'b1);
    data_0 = 8'd0; data_pi = 8'd0;
    wait_idle(300);

    data_0 = 8'h3C; data_pi = 8'hC3;
    exp_q.push_back(16'h13C0); exp_q.push_back(16'h5C30);
    wait_ack(SD + 4);
    // Advance to the low phase of frame B's bit 7, then pulse reset for one cycle.
    repeat (3 + 48*CD) @(negedge clk);
    chk("busy_before_rst", busy, 1'b1);
    chk("cs_low_before_rst", cs_n, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    exp_q.delete();
    data_0 = 8'd0; data_pi = 8'd255;
    exp_q.push_back(16'h1000); exp_q.push_back(16'h5FF0);
    @(negedge clk);
    #2 rst = 1'b0;

    wait_ack(SD + 4);
    chk("no_ldac_after_abort", n_ldac, 0);
    wait_idle(300);
    repeat (4) @(negedge clk);
    chk("ldac_total_after_rst", n_ldac, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("main_overrun", ovr, 1'b0);
    chk("fast_overrun", f_ovr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
